// File: rtl/m_data_mem_pkg.sv
// Shared definitions for the M-stage data memory: access-type encodings,
// default depth, base address and an alignment helper.
// Imported by m_data_mem and m_load_ext.
package m_data_mem_pkg;

    // DMOp encodings (3 bits); 101..111 are reserved
    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_HS = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_BS = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    // Default number of 32-bit words (byte range 0x0000..0x2FFF)
    localparam int unsigned DM_DEPTH_DEFAULT = 3072;

    // Byte address of the first data-memory location
    localparam logic [31:0] DM_BASE_ADDR = 32'h0000_0000;

    // True when the low address bits suit the access size and the op is not reserved
    function automatic logic dm_aligned_ok(input logic [2:0] op, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (op)
            DM_W:         ok = (addr_lo == 2'b00);
            DM_HS, DM_HU: ok = (addr_lo[0] == 1'b0);
            DM_BS, DM_BU: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/m_data_mem_load_ext.sv
// Load extractor: picks word/half/byte from a 32-bit word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module m_load_ext
    import m_data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  dm_op_i,
    output logic [31:0] data_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Select the addressed half and byte (little-endian within the word)
    always_comb begin
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'b00: byte_sel = word_i[7:0];
            2'b01: byte_sel = word_i[15:8];
            2'b10: byte_sel = word_i[23:16];
            2'b11: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
    end

    // Extend the selected field according to the access type; reserved ops give 0
    always_comb begin
        data_o = 32'h0;
        case (dm_op_i)
            DM_W:    data_o = word_i;
            DM_HS:   data_o = {{16{half_sel[15]}}, half_sel};
            DM_HU:   data_o = {16'h0, half_sel};
            DM_BS:   data_o = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   data_o = {24'h0, byte_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_data_mem.sv
// M-stage data memory: word/half/byte stores committed on clk rise, loads combinational.
// Latency: loads 0 cycles, stores visible the cycle after the committing edge.
// Backpressure: none; every access completes in one cycle. Optional macro DM_WRITE_LOG_EN adds a store log.
module m_data_mem
    import m_data_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] PC_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    input  logic [2:0]  DMOp_M,
    input  logic        MemWrite_M,
    output logic [31:0] ReadData_M
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          legal;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word_d;
    logic [31:0]   load_ext;

    // Address decode and legality (range, alignment, non-reserved op)
    always_comb begin
        word_idx = ALUResult_M[2 +: AW];
        in_range = ((ALUResult_M - DM_BASE_ADDR) < BYTE_LIMIT);
        legal    = in_range && dm_aligned_ok(DMOp_M, ALUResult_M[1:0]);
        rd_word  = legal ? mem_q[word_idx] : 32'h0;
    end

    // Merge store data into the current word; untouched bytes keep their old value
    always_comb begin
        wr_word_d = rd_word;
        case (DMOp_M)
            DM_W: wr_word_d = WriteData_M;
            DM_HS, DM_HU: begin
                if (ALUResult_M[1]) wr_word_d[31:16] = WriteData_M[15:0];
                else                wr_word_d[15:0]  = WriteData_M[15:0];
            end
            DM_BS, DM_BU: begin
                case (ALUResult_M[1:0])
                    2'b00: wr_word_d[7:0]   = WriteData_M[7:0];
                    2'b01: wr_word_d[15:8]  = WriteData_M[7:0];
                    2'b10: wr_word_d[23:16] = WriteData_M[7:0];
                    2'b11: wr_word_d[31:24] = WriteData_M[7:0];
                    default: wr_word_d = rd_word;
                endcase
            end
            default: wr_word_d = rd_word;
        endcase
    end

    // Storage: async clear on reset, commit legal stores on the rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (MemWrite_M && legal) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    m_load_ext u_load_ext (
        .word_i    (rd_word),
        .addr_lo_i (ALUResult_M[1:0]),
        .dm_op_i   (DMOp_M),
        .data_o    (load_ext)
    );

    // Force the load result to zero while reset is held, independent of the clock
    always_comb begin
        ReadData_M = reset_n ? load_ext : 32'h0;
    end

`ifdef DM_WRITE_LOG_EN
    // Simulation log of every committed store (dropped stores are silent)
    always_ff @(posedge clk) begin
        if (reset_n && MemWrite_M && legal) begin
            $display("%d@%h: *%h <= %h", $time, PC_M, {ALUResult_M[31:2], 2'b00}, wr_word_d);
        end
    end
`else
    // PC is only meaningful to the store log
    logic unused_pc;
    assign unused_pc = ^PC_M;
`endif

endmodule

// File: tb/tb_m_data_mem.sv
// Self-checking bench for m_data_mem: scoreboard of expected load results.
module tb_m_data_mem;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HS = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_BS = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_RS = 3'b111;

    logic        clk;
    logic        reset_n;
    logic [31:0] PC_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [2:0]  DMOp_M;
    logic        MemWrite_M;
    logic [31:0] ReadData_M;

    int checks;
    int errors;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    m_data_mem dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .PC_M        (PC_M),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .DMOp_M      (DMOp_M),
        .MemWrite_M  (MemWrite_M),
        .ReadData_M  (ReadData_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push an expectation for the current (combinational) read port value
    task automatic expect_rd(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Pop one expectation and compare against the read port
    task automatic pop_check();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, ReadData_M, e);
        end
    endtask

    // Load: drive at the falling edge, sample 2 time units later
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                           input logic [31:0] exp);
        @(negedge clk);
        MemWrite_M  = 1'b0;
        ALUResult_M = addr;
        DMOp_M      = op;
        expect_rd(tag, exp);
        #2;
        pop_check();
    endtask

    // Store: drive at the falling edge, commit at the next rising edge
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] op);
        @(negedge clk);
        ALUResult_M = addr;
        WriteData_M = data;
        DMOp_M      = op;
        MemWrite_M  = 1'b1;
        PC_M        = PC_M + 32'd4;
        @(posedge clk);
        #1;
        MemWrite_M  = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        PC_M        = 32'h0000_3000;
        ALUResult_M = 32'h0;
        WriteData_M = 32'h0;
        DMOp_M      = OP_W;
        MemWrite_M  = 1'b0;

        #12;
        expect_rd("rd_in_reset", 32'h0);
        pop_check();
        #10 reset_n = 1'b1;

        // Word store/load
        do_load ("reset_word0", 32'h0000_0000, OP_W, 32'h0);
        do_store(32'h0000_0004, 32'h1234_5678, OP_W);
        do_load ("lw_0004", 32'h0000_0004, OP_W, 32'h1234_5678);
        do_load ("lw_0000", 32'h0000_0000, OP_W, 32'h0);

        // Byte store and extension
        do_store(32'h0000_0006, 32'h0000_00AB, OP_BS);
        do_load ("lw_merged", 32'h0000_0004, OP_W,  32'h12AB_5678);
        do_load ("lb_0006",   32'h0000_0006, OP_BS, 32'hFFFF_FFAB);
        do_load ("lbu_0006",  32'h0000_0006, OP_BU, 32'h0000_00AB);
        do_load ("lbu_0007",  32'h0000_0007, OP_BU, 32'h0000_0012);
        do_load ("lb_0004",   32'h0000_0004, OP_BS, 32'h0000_0078);

        // Half store and extension
        do_store(32'h0000_000A, 32'h0000_8001, OP_HS);
        do_load ("lh_000A",  32'h0000_000A, OP_HS, 32'hFFFF_8001);
        do_load ("lhu_000A", 32'h0000_000A, OP_HU, 32'h0000_8001);
        do_load ("lh_0008",  32'h0000_0008, OP_HS, 32'h0);
        do_load ("lw_0008",  32'h0000_0008, OP_W,  32'h8001_0000);
        do_store(32'h0000_0008, 32'hFFFF_7FFE, OP_HU);
        do_load ("lh_0008b", 32'h0000_0008, OP_HS, 32'h0000_7FFE);
        do_load ("lw_0008b", 32'h0000_0008, OP_W,  32'h8001_7FFE);

        // Illegal accesses leave memory unchanged and read as zero
        do_store(32'h0000_0002, 32'hDEAD_BEEF, OP_W);
        do_store(32'h0000_3000, 32'hCAFE_F00D, OP_W);
        do_store(32'h0000_0005, 32'h0000_FFFF, OP_HU);
        do_store(32'h0000_0004, 32'h0000_0000, OP_RS);
        do_load ("lw_0000_after_ill", 32'h0000_0000, OP_W,  32'h0);
        do_load ("lw_0004_after_ill", 32'h0000_0004, OP_W,  32'h12AB_5678);
        do_load ("lw_0002_misalign",  32'h0000_0002, OP_W,  32'h0);
        do_load ("lw_3000_range",     32'h0000_3000, OP_W,  32'h0);
        do_load ("lh_0009_misalign",  32'h0000_0009, OP_HS, 32'h0);
        do_load ("ld_reserved_op",    32'h0000_0004, OP_RS, 32'h0);

        // Top word of the address range
        do_store(32'h0000_2FFC, 32'hA5A5_0F0F, OP_W);
        do_load ("lw_2FFC",  32'h0000_2FFC, OP_W,  32'hA5A5_0F0F);
        do_load ("lbu_2FFF", 32'h0000_2FFF, OP_BU, 32'h0000_00A5);

        // Same-cycle store/load returns pre-store contents
        @(negedge clk);
        ALUResult_M = 32'h0000_0004;
        WriteData_M = 32'h0BAD_F00D;
        DMOp_M      = OP_W;
        MemWrite_M  = 1'b1;
        expect_rd("same_cycle_old", 32'h12AB_5678);
        #2;
        pop_check();
        @(posedge clk);
        #1;
        MemWrite_M = 1'b0;
        expect_rd("next_cycle_new", 32'h0BAD_F00D);
        #2;
        pop_check();

        // Back-to-back byte stores to one word merge in sequence
        do_store(32'h0000_0010, 32'h0000_0011, OP_BU);
        do_store(32'h0000_0013, 32'h0000_0044, OP_BS);
        do_load ("b2b_merge", 32'h0000_0010, OP_W, 32'h4400_0011);

        // Reset mid-run: output drops immediately, contents cleared
        do_load("pre_reset_val", 32'h0000_2FFC, OP_W, 32'hA5A5_0F0F);
        #1;
        reset_n = 1'b0;
        #1;
        expect_rd("async_reset_rd", 32'h0);
        pop_check();
        // A store presented while reset is held must be ignored
        MemWrite_M  = 1'b1;
        ALUResult_M = 32'h0000_0020;
        WriteData_M = 32'h7777_7777;
        @(posedge clk);
        #2;
        MemWrite_M = 1'b0;
        reset_n    = 1'b1;
        do_load("post_rst_0004", 32'h0000_0004, OP_W, 32'h0);
        do_load("post_rst_0008", 32'h0000_0008, OP_W, 32'h0);
        do_load("post_rst_0010", 32'h0000_0010, OP_W, 32'h0);
        do_load("post_rst_0020", 32'h0000_0020, OP_W, 32'h0);
        do_load("post_rst_2FFC", 32'h0000_2FFC, OP_W, 32'h0);

        if (exp_q.size() != 0) begin
            chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
